// File: rtl/fb_pkg.sv
// Shared framebuffer constants, FSM state type, pixel record and address helper
// for the pixel framebuffer writer and its FIFO.
package fb_pkg;

    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;
    localparam int ADDR_W    = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    localparam int PIX_W = $bits(pixel_t);

    // y*160 + x built from two shifts and adds, so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        logic [ADDR_W-1:0] yw;
        yw = ADDR_W'(y);
        return (yw << 7) + (yw << 5) + ADDR_W'(x);
    endfunction

    function automatic logic in_frame(input logic [7:0] x, input logic [6:0] y);
        return (x < 8'(FB_WIDTH)) && (y < 7'(FB_HEIGHT));
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO. The head entry stays in the FIFO while its write is
// in flight and is only popped when that write commits. A push into a full
// FIFO is accepted when a pop happens at the same edge. oNext exposes the
// entry behind the head so the writer can issue back-to-back writes.
module pixel_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iPush,
    input  logic [PIX_W-1:0] iData,
    input  logic             iPop,
    output logic [PIX_W-1:0] oHead,
    output logic [PIX_W-1:0] oNext,
    output logic             oFull,
    output logic             oEmpty,
    output logic             oHasNext
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PIX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = iPop && !oEmpty;
    assign do_push = iPush && (!oFull || do_pop);

    // Storage write.
    // NOTE: the storage array has no reset; validity is tracked by count alone.
    always_ff @(posedge iClock) begin
        if (do_push) begin
            mem[wr_ptr] <= iData;
        end
    end

    // Pointer and occupancy bookkeeping; reset flushes the FIFO.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign oEmpty   = (count == '0);
    assign oFull    = (count == CNT_W'(DEPTH));
    assign oHasNext = (count > CNT_W'(1));
    assign oHead    = mem[rd_ptr];
    assign oNext    = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/pixel_fb_writer.sv
// Pixel framebuffer writer: queues the (x,y,colour) pixel stream in a small
// FIFO and writes each pixel into the 160x120x3 framebuffer through a
// granted write port. Also runs full-screen clear sweeps, which take
// priority over queued pixels.
// Optional build macro PIX_DROP_CNT_EN adds oDropCount, a saturating count
// of discarded pixels (overflow drops and out-of-range pixels).
module pixel_fb_writer
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic [7:0]        iX,
    input  logic [6:0]        iY,
    input  logic [2:0]        iColour,
    input  logic              iPlot,
    input  logic              iClear,
    input  logic [2:0]        iClearColour,
    input  logic              iMemGrant,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [2:0]        oMemData,
    output logic              oMemWe,
    output logic              oFull,
    output logic              oBusy,
    output logic              oClearDone,
    output logic              oOverflow
`ifdef PIX_DROP_CNT_EN
    ,
    output logic [7:0]        oDropCount
`endif
);

    wr_state_e         state;
    wr_state_e         state_d;
    logic [ADDR_W-1:0] addr_d;
    logic [2:0]        data_d;
    logic              we_d;
    logic              done_d;
    logic              take_clear;

    logic              clear_pend;
    logic [2:0]        clear_colour;
    logic              clr_req;
    logic [2:0]        clr_colour;

    logic              commit;
    logic              pop;
    logic              push;
    logic              in_range;
    logic              overflow_drop;

    logic              full;
    logic              empty;
    logic              has_next;
    pixel_t            head_pix;
    pixel_t            next_pix;
    pixel_t            push_pix;

    assign commit        = oMemWe && iMemGrant;
    assign pop           = commit && (state == WRITE);
    assign in_range      = in_frame(iX, iY);
    assign push          = iPlot && in_range && (!full || pop);
    assign overflow_drop = iPlot && in_range && full && !pop;
    assign push_pix      = '{x: iX, y: iY, colour: iColour};

    // A clear is requested by a fresh pulse (outside CLEAR) or a remembered one.
    assign clr_req    = clear_pend || (iClear && (state != CLEAR));
    assign clr_colour = clear_pend ? clear_colour : iClearColour;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iClock   (iClock),
        .iReset   (iReset),
        .iPush    (push),
        .iData    (push_pix),
        .iPop     (pop),
        .oHead    (head_pix),
        .oNext    (next_pix),
        .oFull    (full),
        .oEmpty   (empty),
        .oHasNext (has_next)
    );

    // Next-state and next registered write-port values.
    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_d    = state;
        addr_d     = oMemAddr;
        data_d     = oMemData;
        we_d       = oMemWe;
        done_d     = 1'b0;
        take_clear = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_d    = CLEAR;
                    addr_d     = '0;
                    data_d     = clr_colour;
                    we_d       = 1'b1;
                    take_clear = 1'b1;
                end else if (!empty) begin
                    state_d = WRITE;
                    addr_d  = fb_addr(head_pix.x, head_pix.y);
                    data_d  = head_pix.colour;
                    we_d    = 1'b1;
                end
            end
            WRITE: begin
                // A stalled write (valid without grant) holds everything.
                if (!oMemWe || iMemGrant) begin
                    if (clr_req) begin
                        state_d    = CLEAR;
                        addr_d     = '0;
                        data_d     = clr_colour;
                        we_d       = 1'b1;
                        take_clear = 1'b1;
                    end else if (oMemWe && has_next) begin
                        addr_d = fb_addr(next_pix.x, next_pix.y);
                        data_d = next_pix.colour;
                    end else if (!oMemWe && !empty) begin
                        addr_d = fb_addr(head_pix.x, head_pix.y);
                        data_d = head_pix.colour;
                        we_d   = 1'b1;
                    end else begin
                        we_d    = 1'b0;
                        state_d = (oMemWe && push) ? WRITE : IDLE;
                    end
                end
            end
            CLEAR: begin
                if (commit) begin
                    if (oMemAddr == ADDR_W'(FB_WORDS - 1)) begin
                        done_d  = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = '0;
                        state_d = (push || !empty) ? WRITE : IDLE;
                    end else begin
                        addr_d = oMemAddr + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                we_d    = 1'b0;
            end
        endcase
    end

    // State register and registered write port.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state      <= IDLE;
            oMemAddr   <= '0;
            oMemData   <= '0;
            oMemWe     <= 1'b0;
            oClearDone <= 1'b0;
        end else begin
            state      <= state_d;
            oMemAddr   <= addr_d;
            oMemData   <= data_d;
            oMemWe     <= we_d;
            oClearDone <= done_d;
        end
    end

    // Remember a clear request and its colour until the FSM takes it; track overflow.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            clear_pend   <= 1'b0;
            clear_colour <= '0;
            oOverflow    <= 1'b0;
        end else begin
            if (take_clear) begin
                clear_pend <= 1'b0;
            end else if (iClear && (state != CLEAR)) begin
                clear_pend <= 1'b1;
            end
            if (iClear && (state != CLEAR) && !clear_pend) begin
                clear_colour <= iClearColour;
            end
            if (overflow_drop) begin
                oOverflow <= 1'b1;
            end
        end
    end

    assign oFull = full;
    assign oBusy = (state == CLEAR) || !empty;

`ifdef PIX_DROP_CNT_EN
    logic [7:0] drop_cnt;
    logic       drop_evt;

    assign drop_evt = iPlot && (!in_range || overflow_drop);

    // Saturating count of discarded pixels; only reset clears it.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            drop_cnt <= '0;
        end else if (drop_evt && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign oDropCount = drop_cnt;
`else
    // Drop counting is not built in this configuration.
`endif

endmodule
